rgb2raw_bayer: RTL and testbench

// - Re-mosaics an 8-bit RGB pixel stream into a 10-bit raw Bayer sensor-style stream with FVAL/LVAL framing.
// - Inverse of the raw-to-RGB demosaic path: it drives the line-buffer/demosaic chain from memory or a test source, without the camera.
// - Sits between a frame reader (valid/ready RGB) and the CCD-side pixel inputs (data, FVAL, LVAL).

---
 rtl/rgb2raw_bayer.sv | 220 ++++++++++++++++++++++
 tb/tb_rgb2raw_bayer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2raw_bayer.sv
// rgb2raw_bayer
// Re-mosaics an 8-bit RGB pixel stream into a 10-bit raw Bayer stream with
// FVAL/LVAL framing. It is the inverse of the demosaic path, so the line-buffer /
// demosaic chain can be driven from memory or a test source instead of the sensor.
//
// Ports
//   CLK        pixel clock, rising edge
//   RST        asynchronous reset, active-high
//   EN         run frames (sampled only at frame boundaries)
//   iRed/iGreen/iBlue, iVALID   RGB input, pushed on iVALID & oREADY
//   iPATTERN   (TEST_PATTERN_EN only) colour-bar frame select, sampled at frame start
//   oREADY     input FIFO not full
//   oDATA      raw Bayer pixel, channel v expanded as {v, v[7:6]}
//   oFVAL/oLVAL frame / line valid
//   oX_Cont/oY_Cont pixel / line index inside the active window, else 0
//   oUNDERRUN  sticky: an active pixel found the FIFO empty this frame
//
// Build option: define TEST_PATTERN_EN to add the iPATTERN input and the internal
// colour-bar generator. Without it the pixel source is always the FIFO.
module rgb2raw_bayer #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_BLANK     = 160,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_BLANK     = 45,
    parameter logic [1:0]  BAYER_PHASE = 2'd0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [7:0]  iRed,
    input  logic [7:0]  iGreen,
    input  logic [7:0]  iBlue,
    input  logic        iVALID,
`ifdef TEST_PATTERN_EN
    input  logic        iPATTERN,
`endif
    output logic        oREADY,
    output logic [9:0]  oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oUNDERRUN
);

    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [10:0]   H_ACT_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0]   H_BLK_LAST = 11'(H_BLANK - 1);
    localparam logic [10:0]   H_TOT_LAST = 11'(H_ACTIVE + H_BLANK - 1);
    localparam logic [10:0]   V_ACT_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0]   V_BLK_LAST = 11'(V_BLANK - 1);
`ifdef TEST_PATTERN_EN
    localparam logic [10:0]   BAR_W      = 11'(H_ACTIVE / 8);
`endif

    typedef enum logic [1:0] {IDLE, VBLANK, HACTIVE, HBLANK} stateT;

    stateT         state;
    logic [10:0]   hCnt;      // clock within the current line (blank or active)
    logic [10:0]   vCnt;      // blank-line count in VBLANK, active line otherwise

    // Input FIFO
    logic [23:0]   fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   fifoCount;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          doPush;
    logic          doPop;

    logic          patFrame;
    logic          underrunNow;
    logic          rowOdd;
    logic          colOdd;
    logic [23:0]   srcPix;
    logic [7:0]    chan;
    logic [9:0]    pixData;
`ifdef TEST_PATTERN_EN
    logic [2:0]    barIdx;
    logic [23:0]   barPix;
`else
    assign patFrame = 1'b0;
`endif

    assign fifoEmpty   = (fifoCount == '0);
    assign fifoFull    = (fifoCount == FIFO_FULL);
    assign oREADY      = !RST && !fifoFull;
    // A push while full is dropped even if a pop frees a slot on the same clock.
    assign doPush      = iVALID && !fifoFull;
    assign doPop       = (state == HACTIVE) && !patFrame && !fifoEmpty;
    assign underrunNow = (state == HACTIVE) && !patFrame && fifoEmpty;

    always_ff @(posedge CLK) begin
        if (doPush) begin
            fifoMem[wrPtr] <= {iRed, iGreen, iBlue};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            fifoCount <= fifoCount + (AW + 1)'(doPush) - (AW + 1)'(doPop);
        end
    end

    // CFA channel pick and 8->10 bit expansion for the pixel of the current clock
    always_comb begin
        rowOdd = vCnt[0] ^ BAYER_PHASE[1];
        colOdd = hCnt[0] ^ BAYER_PHASE[0];
`ifdef TEST_PATTERN_EN
        barIdx = 3'(hCnt / BAR_W);
        // Bar order white..black is a binary count with R=~b1, G=~b2, B=~b0
        barPix = {{8{~barIdx[1]}}, {8{~barIdx[2]}}, {8{~barIdx[0]}}};
        srcPix = patFrame ? barPix : fifoMem[rdPtr];
`else
        srcPix = fifoMem[rdPtr];
`endif
        if (rowOdd == colOdd) begin
            chan = srcPix[15:8];
        end else if (colOdd) begin
            chan = srcPix[23:16];
        end else begin
            chan = srcPix[7:0];
        end
        pixData = {chan, chan[7:6]};
    end

    // Frame timing FSM with registered outputs (outputs lag the state by one clock)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            hCnt      <= '0;
            vCnt      <= '0;
            oDATA     <= '0;
            oFVAL     <= 1'b0;
            oLVAL     <= 1'b0;
            oX_Cont   <= '0;
            oY_Cont   <= '0;
            oUNDERRUN <= 1'b0;
`ifdef TEST_PATTERN_EN
            patFrame  <= 1'b0;
`endif
        end else begin
            oDATA   <= '0;
            oFVAL   <= 1'b0;
            oLVAL   <= 1'b0;
            oX_Cont <= '0;
            oY_Cont <= '0;
            unique case (state)
                IDLE: begin
                    if (EN) begin
                        state <= VBLANK;
                        hCnt  <= '0;
                        vCnt  <= '0;
                    end
                end
                VBLANK: begin
                    if (hCnt == H_TOT_LAST) begin
                        hCnt <= '0;
                        if (vCnt == V_BLK_LAST) begin
                            state    <= HACTIVE;
                            vCnt     <= '0;
`ifdef TEST_PATTERN_EN
                            patFrame <= iPATTERN;
`endif
                        end else begin
                            vCnt <= vCnt + 11'd1;
                        end
                    end else begin
                        hCnt <= hCnt + 11'd1;
                    end
                end
                HACTIVE: begin
                    oFVAL   <= 1'b1;
                    oLVAL   <= 1'b1;
                    oX_Cont <= hCnt;
                    oY_Cont <= vCnt;
                    oDATA   <= underrunNow ? 10'd0 : pixData;
                    // First pixel of a frame restarts the sticky flag but still counts itself
                    if (hCnt == '0 && vCnt == '0) begin
                        oUNDERRUN <= underrunNow;
                    end else if (underrunNow) begin
                        oUNDERRUN <= 1'b1;
                    end
                    if (hCnt == H_ACT_LAST) begin
                        hCnt  <= '0;
                        state <= HBLANK;
                    end else begin
                        hCnt <= hCnt + 11'd1;
                    end
                end
                HBLANK: begin
                    oFVAL   <= 1'b1;
                    oY_Cont <= vCnt;
                    if (hCnt == H_BLK_LAST) begin
                        hCnt <= '0;
                        if (vCnt == V_ACT_LAST) begin
                            vCnt  <= '0;
                            state <= EN ? VBLANK : IDLE;
                        end else begin
                            vCnt  <= vCnt + 11'd1;
                            state <= HACTIVE;
                        end
                    end else begin
                        hCnt <= hCnt + 11'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb2raw_bayer.sv
// Bench for rgb2raw_bayer. Two instances share all inputs (BAYER_PHASE 0 and 3);
// a frame-position / pixel-queue reference model predicts every output each clock.
module tb_rgb2raw_bayer;

    localparam int H_ACTIVE   = 8;
    localparam int H_BLANK    = 4;
    localparam int V_ACTIVE   = 4;
    localparam int V_BLANK    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int HT         = H_ACTIVE + H_BLANK;
    localparam int VB         = V_BLANK * HT;
    localparam int FRAME      = VB + V_ACTIVE * HT;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        iVALID;
    logic        pattern;
    logic [7:0]  iRed;
    logic [7:0]  iGreen;
    logic [7:0]  iBlue;

    logic        d0Ready, d0Fval, d0Lval, d0Under;
    logic [9:0]  d0Data;
    logic [10:0] d0X, d0Y;
    logic        d3Ready, d3Fval, d3Lval, d3Under;
    logic [9:0]  d3Data;
    logic [10:0] d3X, d3Y;

    int          nChecks = 0;
    int          nFails  = 0;

    // Reference model state
    int          pos;            // frame position of the current clock, -1 = idle
    logic [23:0] fifoQ[$];
    bit          mUnder;
    bit          mPat;
    logic [23:0] seqPix;

    always #5 CLK = ~CLK;

    rgb2raw_bayer #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .V_BLANK(V_BLANK),
        .BAYER_PHASE(2'd0), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut0 (
        .CLK(CLK), .RST(RST), .EN(EN), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iVALID(iVALID),
`ifdef TEST_PATTERN_EN
        .iPATTERN(pattern),
`endif
        .oREADY(d0Ready), .oDATA(d0Data), .oFVAL(d0Fval), .oLVAL(d0Lval),
        .oX_Cont(d0X), .oY_Cont(d0Y), .oUNDERRUN(d0Under)
    );

    rgb2raw_bayer #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .V_BLANK(V_BLANK),
        .BAYER_PHASE(2'd3), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut3 (
        .CLK(CLK), .RST(RST), .EN(EN), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iVALID(iVALID),
`ifdef TEST_PATTERN_EN
        .iPATTERN(pattern),
`endif
        .oREADY(d3Ready), .oDATA(d3Data), .oFVAL(d3Fval), .oLVAL(d3Lval),
        .oX_Cont(d3X), .oY_Cont(d3Y), .oUNDERRUN(d3Under)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t pos=%0d)", tag, got, exp, $time, pos);
        end
    endtask

    function automatic logic [23:0] barColour(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;  // white
            1:       return 24'hFFFF00;  // yellow
            2:       return 24'h00FFFF;  // cyan
            3:       return 24'h00FF00;  // green
            4:       return 24'hFF00FF;  // magenta
            5:       return 24'hFF0000;  // red
            6:       return 24'h0000FF;  // blue
            default: return 24'h000000;  // black
        endcase
    endfunction

    // Raw value for an RGB pixel at (line, x) under a given CFA phase
    function automatic int rawOf(input logic [23:0] pix, input int line, input int x,
                                 input int phase);
        int rr, cc, v;
        rr = (line + phase / 2) % 2;
        cc = (x + phase % 2) % 2;
        if (rr == cc)      v = int'(pix[15:8]);
        else if (rr == 0)  v = int'(pix[23:16]);
        else               v = int'(pix[7:0]);
        return v * 4 + v / 64;
    endfunction

    task automatic checkZero(input string tag);
        checkEq({tag, ".ready0"}, 32'(d0Ready), 0);
        checkEq({tag, ".data0"},  32'(d0Data),  0);
        checkEq({tag, ".fval0"},  32'(d0Fval),  0);
        checkEq({tag, ".lval0"},  32'(d0Lval),  0);
        checkEq({tag, ".x0"},     32'(d0X),     0);
        checkEq({tag, ".y0"},     32'(d0Y),     0);
        checkEq({tag, ".under0"}, 32'(d0Under), 0);
        checkEq({tag, ".ready3"}, 32'(d3Ready), 0);
        checkEq({tag, ".data3"},  32'(d3Data),  0);
        checkEq({tag, ".fval3"},  32'(d3Fval),  0);
        checkEq({tag, ".under3"}, 32'(d3Under), 0);
    endtask

    // Called just after a rising edge: predict what that edge registered.
    task automatic modelStep();
        int          eF, eL, eX, eY, eD0, eD3, q, line, x, cntBefore;
        bit          und, have;
        logic [23:0] pix;
        eF = 0; eL = 0; eX = 0; eY = 0; eD0 = 0; eD3 = 0;
        und = 0; have = 0; pix = '0;
        cntBefore = fifoQ.size();
        if (pos >= VB) begin
            q    = pos - VB;
            line = q / HT;
            x    = q % HT;
            eF   = 1;
            eY   = line;
            if (x < H_ACTIVE) begin
                eL = 1;
                eX = x;
                if (mPat) begin
                    pix  = barColour(x / (H_ACTIVE / 8));
                    have = 1;
                end else if (cntBefore > 0) begin
                    pix  = fifoQ.pop_front();
                    have = 1;
                end else begin
                    und = 1;
                end
                if (have) begin
                    eD0 = rawOf(pix, line, x, 0);
                    eD3 = rawOf(pix, line, x, 3);
                end
            end
            if (pos == VB) mUnder = und;
            else if (und)  mUnder = 1;
        end
        if (iVALID && cntBefore < FIFO_DEPTH) fifoQ.push_back({iRed, iGreen, iBlue});
`ifdef TEST_PATTERN_EN
        if (pos == VB - 1) mPat = pattern;
`endif
        if (pos < 0 || pos == FRAME - 1) pos = EN ? 0 : -1;
        else                             pos = pos + 1;

        checkEq("fval",   32'(d0Fval),  32'(eF));
        checkEq("lval",   32'(d0Lval),  32'(eL));
        checkEq("xcont",  32'(d0X),     32'(eX));
        checkEq("ycont",  32'(d0Y),     32'(eY));
        checkEq("data0",  32'(d0Data),  32'(eD0));
        checkEq("data3",  32'(d3Data),  32'(eD3));
        checkEq("under0", 32'(d0Under), 32'(mUnder));
        checkEq("under3", 32'(d3Under), 32'(mUnder));
        checkEq("ready",  32'(d0Ready), 32'(fifoQ.size() != FIFO_DEPTH));
        checkEq("fval3",  32'(d3Fval),  32'(eF));
    endtask

    // enMode: 0/1 level, 2 = high until line 1 pixel 4 of the current frame
    // vldMode: 0/1 level, 2 = random, 3 = low during line 2 active pixels
    // dataMode: 0 = constant FF/80/00, 1 = incrementing, 2 = random
    task automatic tick(input int enMode, input int vldMode, input int dataMode, input bit pat);
        @(negedge CLK);
        modelStep();
        case (enMode)
            0:       EN = 1'b0;
            1:       EN = 1'b1;
            default: EN = (pos >= 0 && pos < VB + HT + 4);
        endcase
        case (vldMode)
            0:       iVALID = 1'b0;
            1:       iVALID = 1'b1;
            2:       iVALID = 1'($urandom_range(0, 1));
            default: iVALID = !(pos >= VB + 2 * HT && pos < VB + 2 * HT + H_ACTIVE);
        endcase
        case (dataMode)
            0: {iRed, iGreen, iBlue} = 24'hFF8000;
            1: begin
                {iRed, iGreen, iBlue} = seqPix;
                seqPix = seqPix + 24'h010203;
            end
            default: {iRed, iGreen, iBlue} = 24'($urandom);
        endcase
        pattern = pat;
    endtask

    task automatic runUntil(input int tgt, input int enMode, input int vldMode,
                            input int dataMode, input bit pat);
        int n;
        n = 0;
        do begin
            tick(enMode, vldMode, dataMode, pat);
            n++;
        end while (pos != tgt && n < 500);
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; iVALID = 1'b0; pattern = 1'b0;
        iRed = '0; iGreen = '0; iBlue = '0;
        pos = -1; mUnder = 0; mPat = 0; seqPix = 24'h102030;

        repeat (3) @(negedge CLK);
        checkZero("reset");
        RST = 1'b0;
        #1;
        checkEq("readyAfterReset0", 32'(d0Ready), 1);
        checkEq("readyAfterReset3", 32'(d3Ready), 1);

        repeat (4) tick(0, 0, 0, 0);              // idle, nothing starts
        runUntil(0, 1, 1, 0, 0);                  // EN=1 starts vertical blank
        runUntil(FRAME - 1, 1, 1, 0, 0);          // constant colour, FIFO full in blanking
        runUntil(0, 1, 1, 1, 0);
        runUntil(FRAME - 1, 1, 3, 1, 0);          // incrementing data, starve line 2
        runUntil(0, 1, 1, 1, 0);
        runUntil(-1, 2, 2, 2, 0);                 // random, EN dropped mid line 1
        repeat (20) tick(0, 2, 2, 0);             // stays idle, FIFO fills
        runUntil(0, 1, 2, 2, 1);
        runUntil(FRAME - 1, 1, 2, 2, 1);          // colour-bar frame when built with it
        runUntil(VB + 2 * HT + 3, 1, 2, 2, 0);    // mid line 2 of the next frame

        RST = 1'b1;
        #1;
        checkZero("midFrameReset");
        fifoQ.delete();
        pos = -1; mUnder = 0; mPat = 0;
        EN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkEq("readyAfterMidReset", 32'(d0Ready), 1);
        repeat (8) tick(0, 2, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
